serial_digit_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor. It processes a WIDTH-bit operand pair DIGIT bits per clock, LSB digit first, through one DIGIT-bit ripple-carry slice built from full-adder cells. A registered carry links successive digits. It is the area-lean successor to the single-bit structural full adder. Operands enter and results leave over valid/ready handshakes, so it drops into datapaths with back-pressure.

---
 rtl/adder_pkg.sv | 10 +
 rtl/serial_digit_adder_if.sv | 29 ++
 rtl/digit_ripple_adder.sv | 33 +++
 rtl/serial_digit_adder.sv | 115 +++++++++++
 tb/tb_serial_digit_adder.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared FSM state type and digit-count helper for serial_digit_adder
package adder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int num_digits(input int width, input int digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/serial_digit_adder_if.sv
// serial_digit_adder_if: operand/result handshake bundle for serial_digit_adder
//   in_valid/in_ready   : operand pair handshake (a, b, carry_in, sub)
//   out_valid/out_ready : result handshake (sum, carry_out, overflow)
//   master drives operands and out_ready; slave (the adder) drives the rest
interface serial_digit_adder_if #(parameter int WIDTH = 16);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    modport master (
        output in_valid, a, b, carry_in, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow
    );

    modport slave (
        input  in_valid, a, b, carry_in, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow
    );

endinterface

// File: rtl/digit_ripple_adder.sv
// digit_ripple_adder: combinational DIGIT-bit ripple chain of full-adder cells
//   a, b  : digit operands
//   cin   : carry into bit 0
//   s     : digit sum
//   cout  : carry out of the top bit
//   c_msb : carry into the top bit (for overflow detection)
module digit_ripple_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    always_comb begin
        s = '0;
        c = '0;
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            s[i] = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_digit_adder.sv
// serial_digit_adder: multi-cycle WIDTH-bit adder/subtractor, DIGIT bits per clock
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of serial_digit_adder_if (operands in, result out)
module serial_digit_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    serial_digit_adder_if.slave bus
);

    localparam int N  = num_digits(WIDTH, DIGIT);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 1 || DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad_params
        $error("serial_digit_adder: WIDTH must be >= 1 and a multiple of DIGIT");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [DIGIT-1:0] dsum;
    logic             dcout;
    logic             dcmsb;

    digit_ripple_adder #(.DIGIT(DIGIT)) u_slice (
        .a     (a_q[DIGIT-1:0]),
        .b     (b_q[DIGIT-1:0]),
        .cin   (carry_q),
        .s     (dsum),
        .cout  (dcout),
        .c_msb (dcmsb)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        case (state_q)
            IDLE: if (in_ready_q && bus.in_valid) begin
                a_d     = bus.a;
                // subtraction is a + ~b + 1, so the carry seed is forced to 1
                b_d     = bus.sub ? ~bus.b : bus.b;
                carry_d = bus.sub | bus.carry_in;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                // new digit enters at the top; after N shifts digit 0 sits at bit 0
                sum_d   = (sum_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
                carry_d = dcout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    carry_out_d = dcout;
                    overflow_d  = dcout ^ dcmsb;
                    state_d     = DONE;
                end
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        in_ready_d  = state_d == IDLE;
        out_valid_d = state_d == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.carry_out = carry_out_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_serial_digit_adder.sv
// tb_serial_digit_adder: self-checking bench for WIDTH=8 with DIGIT=2 and DIGIT=8
module tb_serial_digit_adder;

    typedef struct packed {logic [7:0] s; logic c; logic v;} res_t;
    typedef struct packed {logic [7:0] a; logic [7:0] b; logic ci; logic sb; res_t e;} vec_t;

    localparam vec_t DV [8] = '{
        {8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0},
        {8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1},
        {8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1},
        {8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0},
        {8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1},
        {8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0},
        {8'h3C, 8'hC4, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0},
        {8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0}
    };

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    res_t q2[$];
    res_t q8[$];

    always #5 clk = ~clk;

    serial_digit_adder_if #(.WIDTH(8)) b2 ();
    serial_digit_adder_if #(.WIDTH(8)) b8 ();

    serial_digit_adder #(.WIDTH(8), .DIGIT(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    serial_digit_adder #(.WIDTH(8), .DIGIT(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values
    function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sb);
        int   sa, sbb, ua, ub, r;
        res_t x;
        sa  = int'($signed(a));
        sbb = int'($signed(b));
        ua  = int'(a);
        ub  = int'(b);
        if (sb) begin
            r   = sa - sbb;
            x.c = ua >= ub;
            x.s = 8'(ua - ub);
        end else begin
            r   = sa + sbb + int'(ci);
            x.c = (ua + ub + int'(ci)) > 255;
            x.s = 8'(ua + ub + int'(ci));
        end
        x.v = r > 127 || r < -128;
        return x;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic sb);
        if (sel == 0) begin
            b2.in_valid = v; b2.a = a; b2.b = b; b2.carry_in = ci; b2.sub = sb;
        end else begin
            b8.in_valid = v; b8.a = a; b8.b = b; b8.carry_in = ci; b8.sub = sb;
        end
    endtask

    function automatic logic rdy(input int sel);
        return sel == 0 ? b2.in_ready : b8.in_ready;
    endfunction

    function automatic logic ovalid(input int sel);
        return sel == 0 ? b2.out_valid : b8.out_valid;
    endfunction

    task automatic op(input int sel, input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input logic sb, input res_t e);
        int n = 0;
        while (!rdy(sel) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_wait", 32'(rdy(sel)), 1);
        drive(sel, 1'b1, a, b, ci, sb);
        @(posedge clk);
        if (sel == 0) q2.push_back(e); else q8.push_back(e);
        #1 drive(sel, 1'b0, ~a, ~b, ~ci, ~sb);
        n = 0;
        while (!ovalid(sel) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk(sel == 0 ? "latency2" : "latency8", n, sel == 0 ? 4 : 1);
    endtask

    always @(negedge clk) begin
        if (rst_n && b2.out_valid) begin
            chk("in_ready_in_done2", 32'(b2.in_ready), 0);
            chk("pending2", 32'(q2.size() != 0), 1);
            if (q2.size() != 0) begin
                chk("result2", 32'({b2.sum, b2.carry_out, b2.overflow}), 32'(q2[0]));
                if (b2.out_ready) void'(q2.pop_front());
            end
        end
        if (rst_n && b8.out_valid) begin
            chk("in_ready_in_done8", 32'(b8.in_ready), 0);
            chk("pending8", 32'(q8.size() != 0), 1);
            if (q8.size() != 0) begin
                chk("result8", 32'({b8.sum, b8.carry_out, b8.overflow}), 32'(q8[0]));
                if (b8.out_ready) void'(q8.pop_front());
            end
        end
    end

    initial begin
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        drive(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        b2.out_ready = 1'b1;
        b8.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready2", 32'(b2.in_ready), 0);
        chk("rst_out_valid2", 32'(b2.out_valid), 0);
        chk("rst_outs2", 32'({b2.sum, b2.carry_out, b2.overflow}), 0);
        chk("rst_in_ready8", 32'(b8.in_ready), 0);
        rst_n = 1'b1;
        chk("in_ready_before_edge", 32'(b2.in_ready), 0);
        @(posedge clk); #1;
        chk("in_ready_after_rst2", 32'(b2.in_ready), 1);
        chk("in_ready_after_rst8", 32'(b8.in_ready), 1);

        for (int i = 0; i < 8; i++) begin
            chk($sformatf("model_pin%0d", i), 32'(model(DV[i].a, DV[i].b, DV[i].ci, DV[i].sb)), 32'(DV[i].e));
            op(0, DV[i].a, DV[i].b, DV[i].ci, DV[i].sb, DV[i].e);
            op(1, DV[i].a, DV[i].b, DV[i].ci, DV[i].sb, DV[i].e);
        end

        b2.out_ready = 1'b0;
        op(0, 8'h33, 8'h44, 1'b0, 1'b0, {8'h77, 1'b0, 1'b0});
        drive(0, 1'b1, 8'hAA, 8'h55, 1'b1, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        chk("bp_in_ready", 32'(b2.in_ready), 0);
        chk("bp_out_valid", 32'(b2.out_valid), 1);
        chk("bp_sum", 32'(b2.sum), 32'h77);
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        b2.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_hs_in_ready", 32'(b2.in_ready), 1);
        chk("post_hs_out_valid", 32'(b2.out_valid), 0);
        op(0, 8'h01, 8'h02, 1'b1, 1'b0, {8'h04, 1'b0, 1'b0});

        drive(0, 1'b1, 8'h55, 8'h22, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_valid", 32'(b2.out_valid), 0);
        chk("midrun_rst_ready", 32'(b2.in_ready), 0);
        chk("midrun_rst_outs", 32'({b2.sum, b2.carry_out, b2.overflow}), 0);
        q2.delete();
        q8.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_release_ready", 32'(b2.in_ready), 1);
        op(0, 8'h12, 8'h34, 1'b0, 1'b0, {8'h46, 1'b0, 1'b0});

        for (int i = 0; i < 20; i++) begin
            logic [7:0] ra, rb;
            logic rc, rs;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            op(i % 2, ra, rb, rc, rs, model(ra, rb, rc, rs));
        end

        repeat (5) @(posedge clk);
        #1;
        chk("drained2", 32'(q2.size()), 0);
        chk("drained8", 32'(q8.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
